jtopl_pg_seq: RTL

// - Phase-generator sequencer for the OPL core. Time-multiplexes one jtopl_pg_sum datapath across 18 operator slots.
// - Holds per-slot phase accumulators and per-slot frequency/mul configuration.
// - Detects key-on edges and drives pg_rst.
// - Emits one 10-bit operator phase per slot per sweep, tagged with its slot number, to the operator stage.

---
 rtl/jtopl_pg_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/jtopl_pg_seq.sv
// Phase-generator sequencer: time-multiplexes one jtopl_pg_sum datapath across SLOTS operator slots.
// Define JTOPL_PG_VIB_EN to add the per-slot vibrato enable (i_cfg_vib) and the vib_pos counter.
module jtopl_pg_seq #(
   parameter int unsigned SLOTS  = 18,
   parameter int unsigned SLOT_W = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cen,
   input  logic              i_cfg_we,
   input  logic [SLOT_W-1:0] i_cfg_slot,
   input  logic [9:0]        i_cfg_fnum,
   input  logic [2:0]        i_cfg_block,
   input  logic [3:0]        i_cfg_mul,
   input  logic              i_cfg_keyon,
`ifdef JTOPL_PG_VIB_EN
   input  logic              i_cfg_vib,
`endif
   output logic [3:0]        o_pgs_mul,
   output logic [18:0]       o_pgs_phin,
   output logic              o_pgs_rst,
   output logic [16:0]       o_pgs_phinc,
   input  logic [18:0]       i_pgs_phout,
   input  logic [9:0]        i_pgs_phop,
   output logic [9:0]        o_op_phase,
   output logic [SLOT_W-1:0] o_op_slot,
   output logic              o_op_valid
);
   localparam logic [SLOT_W-1:0] LastSlot = SLOT_W'(SLOTS - 1);

   logic [SLOT_W-1:0] r_slot;
   logic [18:0]       r_phase    [SLOTS];
   logic [9:0]        r_fnum     [SLOTS];
   logic [2:0]        r_block    [SLOTS];
   logic [3:0]        r_mul      [SLOTS];
   logic              r_keyon    [SLOTS];
   logic              r_kon_prev [SLOTS];
   logic [9:0]        r_op_phase;
   logic [SLOT_W-1:0] r_op_slot;
   logic              r_op_valid;

   logic [9:0]        w_fnum_eff;
   logic [16:0]       w_phinc_sh;
   logic              w_wrap;
   logic              w_cfg_hit;

   assign w_wrap    = (r_slot == LastSlot);
   assign w_cfg_hit = i_cfg_we && (i_cfg_slot <= LastSlot);

`ifdef JTOPL_PG_VIB_EN
   logic       r_vib [SLOTS];
   logic [2:0] r_vib_pos;
   logic [9:0] r_sweep_cnt;
   logic [2:0] w_vib_f;
   logic [9:0] w_vib_mag;

   // Odd positions use f/2, positions 2 and 6 use f; the upper half of the cycle subtracts.
   always_comb begin
      w_vib_f   = r_fnum[r_slot][9:7];
      w_vib_mag = r_vib_pos[0] ? {8'd0, w_vib_f[2:1]} :
                  r_vib_pos[1] ? {7'd0, w_vib_f} : 10'd0;
      if (!r_vib[r_slot]) begin
         w_fnum_eff = r_fnum[r_slot];
      end else if (r_vib_pos[2]) begin
         w_fnum_eff = r_fnum[r_slot] - w_vib_mag;
      end else begin
         w_fnum_eff = r_fnum[r_slot] + w_vib_mag;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vib_pos   <= '0;
         r_sweep_cnt <= '0;
         for (int unsigned i = 0; i < SLOTS; i++) begin
            r_vib[i] <= 1'b0;
         end
      end else begin
         if (i_cen && w_wrap) begin
            r_sweep_cnt <= r_sweep_cnt + 10'd1;
            if (r_sweep_cnt == 10'h3FF) begin
               r_vib_pos <= r_vib_pos + 3'd1;
            end
         end
         if (w_cfg_hit) begin
            r_vib[i_cfg_slot] <= i_cfg_vib;
         end
      end
   end
`else
   assign w_fnum_eff = r_fnum[r_slot];
`endif

   always_comb begin
      w_phinc_sh  = {7'd0, w_fnum_eff} << r_block[r_slot];
      o_pgs_phinc = w_phinc_sh >> 1;
   end

   assign o_pgs_mul  = r_mul[r_slot];
   assign o_pgs_phin = r_phase[r_slot];
   assign o_pgs_rst  = r_keyon[r_slot] & ~r_kon_prev[r_slot];
   assign o_op_phase = r_op_phase;
   assign o_op_slot  = r_op_slot;
   assign o_op_valid = r_op_valid;

   // A same-cycle config write to the visited slot only lands after this visit has used the old values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_slot     <= '0;
         r_op_phase <= '0;
         r_op_slot  <= '0;
         r_op_valid <= 1'b0;
         for (int unsigned i = 0; i < SLOTS; i++) begin
            r_phase[i]    <= '0;
            r_fnum[i]     <= '0;
            r_block[i]    <= '0;
            r_mul[i]      <= '0;
            r_keyon[i]    <= 1'b0;
            r_kon_prev[i] <= 1'b0;
         end
      end else begin
         if (i_cen) begin
            r_phase[r_slot]    <= i_pgs_phout;
            r_kon_prev[r_slot] <= r_keyon[r_slot];
            r_op_phase         <= i_pgs_phop;
            r_op_slot          <= r_slot;
            r_op_valid         <= 1'b1;
            r_slot             <= w_wrap ? '0 : r_slot + 1'b1;
         end else begin
            r_op_valid <= 1'b0;
         end
         if (w_cfg_hit) begin
            r_fnum[i_cfg_slot]  <= i_cfg_fnum;
            r_block[i_cfg_slot] <= i_cfg_block;
            r_mul[i_cfg_slot]   <= i_cfg_mul;
            r_keyon[i_cfg_slot] <= i_cfg_keyon;
         end
      end
   end

endmodule
